// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: funct3 size codes, FSM state
// enum and small decode helpers used by mem_access_unit and lsu_align.
// Configuration: MISALIGN_TRAP_EN (used by mem_access_unit) selects whether
// misaligned H/HU/W accesses trap or are forced to alignment.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // funct3 size codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Reserved size codes, and unsigned variants on a store, have no meaning.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
               (we && funct3[2]);
    endfunction

    // Half accesses on odd bytes and word accesses off a word boundary.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3 == F3_W) && (addr_lo != 2'b00));
    endfunction

    // Byte enables for a legal store; half/word are forced to alignment.
    function automatic logic [3:0] store_byteena(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the byte enables pick the right one.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        case (funct3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational load-data alignment: picks the addressed byte/half lane out of
// a memory word and sign- or zero-extends it according to funct3.
// Ports:
//   mem_q_i    [31:0] word read from data memory
//   addr_i     [1:0]  byte offset within the word
//   funct3_i   [2:0]  size code (B, H, W, BU, HU)
//   result_o   [31:0] aligned, extended load result (0 for reserved codes)
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_q_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        byte_lane = mem_q_i[7:0];
        case (addr_i)
            2'd0:    byte_lane = mem_q_i[7:0];
            2'd1:    byte_lane = mem_q_i[15:8];
            2'd2:    byte_lane = mem_q_i[23:16];
            default: byte_lane = mem_q_i[31:24];
        endcase

        // Half lane uses addr[1] only: alignment is forced on halves.
        half_lane = addr_i[1] ? mem_q_i[31:16] : mem_q_i[15:0];

        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    result_o = {{16{half_lane[15]}}, half_lane};
            F3_W:    result_o = mem_q_i;
            F3_BU:   result_o = {24'h0, byte_lane};
            F3_HU:   result_o = {16'h0, half_lane};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Single-outstanding load/store unit between a valid/ready request channel and
// a word-addressed synchronous data memory (read data valid one cycle after
// the read address). Loads take three cycles to a response, stores two and
// illegal requests one. Responses are held until accepted.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_we, req_funct3            store(1)/load(0), size code
//   req_addr, req_wdata           byte address, store data
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          load result, access fault
//   mem_rdaddress, mem_wraddress  word address (addr[16:2])
//   mem_byteena, mem_data         store byte enables and lane-replicated data
//   mem_wren, mem_q               write strobe, registered read data
//
// Configuration macro MISALIGN_TRAP_EN: when defined, misaligned H/HU/W
// accesses fault without touching memory; otherwise alignment is forced.
// -----------------------------------------------------------------------------
module mem_access_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic [14:0] mem_rdaddress,
    output logic [14:0] mem_wraddress,
    output logic [3:0]  mem_byteena,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

    lsu_state_e  state_q, state_d;

    // Captured request; only the address bits that reach memory are kept.
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [16:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_illegal;
    logic [31:0] align_result;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:17];

    assign accept = (state_q == ST_IDLE) && req_valid;

    always_comb begin
        req_illegal = funct3_illegal(req_we, req_funct3);
`ifdef MISALIGN_TRAP_EN
        req_illegal = req_illegal || misaligned(req_funct3, req_addr[1:0]);
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = req_illegal ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT:   state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q         <= req_we;
                funct3_q     <= req_funct3;
                addr_q       <= req_addr[16:0];
                wdata_q      <= req_wdata;
                // Stores and faults respond with zero data; loads overwrite in WAIT.
                resp_rdata_q <= '0;
                resp_err_q   <= req_illegal;
            end
            if (state_q == ST_WAIT) begin
                resp_rdata_q <= align_result;
            end
        end
    end

    lsu_align u_align (
        .mem_q_i  (mem_q),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .result_o (align_result)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign mem_rdaddress = addr_q[16:2];
    assign mem_wraddress = addr_q[16:2];
    assign mem_data      = store_data(funct3_q, wdata_q);

    // Reset is folded into the strobe so a store caught in ACCESS by reset
    // never commits at the reset edge.
    assign mem_wren    = (state_q == ST_ACCESS) && we_q && !rst;
    assign mem_byteena = mem_wren ? store_byteena(funct3_q, addr_q[1:0]) : 4'b0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench: a byte-addressed transaction-level reference model
// predicts handshakes, write strobes and responses; one compare process checks
// the DUT against it every cycle. Directed transactions pin the model with
// hand-computed values, then a randomized phase runs with random resets.
// Honours MISALIGN_TRAP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [14:0] mem_rdaddress, mem_wraddress;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data, mem_q;
    logic        mem_wren;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_rdaddress (mem_rdaddress),
        .mem_wraddress (mem_wraddress),
        .mem_byteena   (mem_byteena),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .mem_q         (mem_q)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- environment memory (what the DUT talks to) ----------
    logic [31:0] env_mem [0:32767];
    int          wr_count = 0;
    logic [3:0]  last_be;
    logic [31:0] last_data;
    logic [14:0] last_waddr;

    always @(posedge clk) begin
        mem_q <= env_mem[mem_rdaddress];
        if (mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteena[b]) env_mem[mem_wraddress][8*b +: 8] <= mem_data[8*b +: 8];
            end
            wr_count   <= wr_count + 1;
            last_be    <= mem_byteena;
            last_data  <= mem_data;
            last_waddr <= mem_wraddress;
        end
    end

    // ---------------- reference model (byte-addressed, per transaction) ---
    logic [7:0]  ref_mem [0:131071];
    bit          m_idle = 1'b1;
    bit          m_in_resp = 1'b0;
    bit          m_store, m_load, m_err;
    int          m_cyc, m_lat, m_size, m_start;
    logic [31:0] m_rdata, m_wdata, m_mdata;
    logic [3:0]  m_be;
    bit          started = 1'b0;

    task automatic model_accept();
        int  size, start, a;
        bit  illegal;
        logic [31:0] v;
        a       = int'(req_addr[16:0]);
        size    = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
        illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7) ||
                  (req_we && req_funct3 >= 3'd4);
`ifdef MISALIGN_TRAP_EN
        if (!illegal && (a % size) != 0) illegal = 1'b1;
`endif
        start     = a - (a % size);
        m_idle    = 1'b0;
        m_cyc     = 1;
        m_err     = illegal;
        m_rdata   = 32'h0;
        m_store   = 1'b0;
        m_load    = 1'b0;
        m_size    = size;
        m_start   = start;
        if (illegal) begin
            m_lat = 1;
        end else if (req_we) begin
            m_store = 1'b1;
            m_lat   = 2;
            m_wdata = req_wdata;
            m_be    = 4'(((1 << size) - 1) << (start % 4));
            m_mdata = (size == 1) ? req_wdata[7:0] * 32'h0101_0101 :
                      (size == 2) ? req_wdata[15:0] * 32'h0001_0001 : req_wdata;
        end else begin
            m_load = 1'b1;
            m_lat  = 3;
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[start + i]) << (8 * i));
            if (!req_funct3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!req_funct3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
            m_rdata = v;
        end
        m_in_resp = (m_lat == 1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_idle    = 1'b1;
            m_in_resp = 1'b0;
        end else begin
            if (!m_idle && m_store && m_cyc == 1) begin
                for (int i = 0; i < m_size; i++) ref_mem[m_start + i] = m_wdata[8*i +: 8];
            end
            if (m_idle) begin
                if (req_valid) model_accept();
            end else if (m_in_resp) begin
                if (resp_ready) begin
                    m_idle    = 1'b1;
                    m_in_resp = 1'b0;
                end
            end else begin
                m_cyc++;
                m_in_resp = (m_cyc == m_lat);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit exp_wr;
        if (started) begin
            check("req_ready", {31'b0, req_ready}, {31'b0, m_idle});
            check("resp_valid", {31'b0, resp_valid}, {31'b0, m_in_resp});
            if (m_in_resp) begin
                check("resp_rdata", resp_rdata, m_rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, m_err});
            end
            exp_wr = !m_idle && m_store && (m_cyc == 1) && !rst;
            check("mem_wren", {31'b0, mem_wren}, {31'b0, exp_wr});
            check("mem_byteena", {28'b0, mem_byteena}, exp_wr ? {28'b0, m_be} : 32'h0);
            if (exp_wr) begin
                check("mem_wraddress", {17'b0, mem_wraddress}, 32'(m_start / 4));
                check("mem_data", mem_data, m_mdata);
            end
            if (!m_idle && m_load && m_cyc == 1) begin
                check("mem_rdaddress", {17'b0, mem_rdaddress}, 32'(m_start / 4));
            end
        end
    end

    // ---------------- directed transaction helper ----------------
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           output logic [31:0] rd, output logic err,
                           output int lat, output int wr_delta);
        int w0;
        @(negedge clk);
        #1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        w0 = wr_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        rd  = 32'h0;
        err = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("resp_timeout", {31'b0, resp_valid}, 32'h1);
        rd  = resp_rdata;
        err = resp_err;
        for (int k = 0; k < hold; k++) begin
            // A competing store while the response is stalled must be dropped.
            #1;
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = F3_W;
            req_addr   = 32'h0000_0200;
            req_wdata  = 32'h5555_5555;
            @(negedge clk);
            check("hold_resp_valid", {31'b0, resp_valid}, 32'h1);
            check("hold_resp_rdata", resp_rdata, rd);
            check("hold_resp_err", {31'b0, resp_err}, {31'b0, err});
            check("hold_req_ready", {31'b0, req_ready}, 32'h0);
        end
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        wr_delta = wr_count - w0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat, wd, w0;

        for (int w = 0; w < 32768; w++) begin
            env_mem[w] = (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = env_mem[w][8*b +: 8];
        end

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        @(posedge clk);
        started = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("reset_resp_rdata", resp_rdata, 32'h0);
        check("reset_resp_err", {31'b0, resp_err}, 32'h0);
        check("reset_mem_wren", {31'b0, mem_wren}, 32'h0);
        check("reset_mem_byteena", {28'b0, mem_byteena}, 32'h0);
        check("reset_mem_rdaddress", {17'b0, mem_rdaddress}, 32'h0);

        // SW / LW round trip
        run_txn(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 0, rd, err, lat, wd);
        check("sw_lat", lat, 2);
        check("sw_rdata", rd, 32'h0);
        check("sw_err", {31'b0, err}, 32'h0);
        check("sw_writes", wd, 1);
        check("sw_byteena", {28'b0, last_be}, 32'hF);
        check("sw_wraddress", {17'b0, last_waddr}, 32'h040);
        check("sw_data", last_data, 32'hDEAD_BEEF);
        run_txn(1'b0, F3_W, 32'h100, 32'h0, 0, rd, err, lat, wd);
        check("lw_lat", lat, 3);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_writes", wd, 0);

        // byte store / loads
        run_txn(1'b1, F3_B, 32'h103, 32'h1234_56A5, 0, rd, err, lat, wd);
        check("sb_byteena", {28'b0, last_be}, 32'h8);
        check("sb_data", last_data, 32'hA5A5_A5A5);
        check("sb_writes", wd, 1);
        run_txn(1'b0, F3_B, 32'h103, 32'h0, 0, rd, err, lat, wd);
        check("lb_rdata", rd, 32'hFFFF_FFA5);
        run_txn(1'b0, F3_BU, 32'h103, 32'h0, 0, rd, err, lat, wd);
        check("lbu_rdata", rd, 32'h0000_00A5);

        // half store / loads
        run_txn(1'b1, F3_H, 32'h102, 32'hCAFE_8001, 0, rd, err, lat, wd);
        check("sh_byteena", {28'b0, last_be}, 32'hC);
        check("sh_data", last_data, 32'h8001_8001);
        run_txn(1'b0, F3_H, 32'h102, 32'h0, 0, rd, err, lat, wd);
        check("lh_rdata", rd, 32'hFFFF_8001);
        run_txn(1'b0, F3_HU, 32'h102, 32'h0, 0, rd, err, lat, wd);
        check("lhu_rdata", rd, 32'h0000_8001);

        // misaligned word load
        run_txn(1'b0, F3_W, 32'h101, 32'h0, 0, rd, err, lat, wd);
`ifdef MISALIGN_TRAP_EN
        check("lw_mis_lat", lat, 1);
        check("lw_mis_err", {31'b0, err}, 32'h1);
        check("lw_mis_rdata", rd, 32'h0);
`else
        check("lw_mis_lat", lat, 3);
        check("lw_mis_err", {31'b0, err}, 32'h0);
        check("lw_mis_rdata", rd, 32'h8001_BEEF);
`endif
        check("lw_mis_writes", wd, 0);

        // illegal codes
        run_txn(1'b1, F3_BU, 32'h100, 32'h1111_1111, 0, rd, err, lat, wd);
        check("sbu_illegal_lat", lat, 1);
        check("sbu_illegal_err", {31'b0, err}, 32'h1);
        check("sbu_illegal_writes", wd, 0);
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 0, rd, err, lat, wd);
        check("f3_011_err", {31'b0, err}, 32'h1);
        check("f3_011_rdata", rd, 32'h0);

        // upper address bits ignored
        run_txn(1'b0, F3_W, 32'hFFFE_0100, 32'h0, 0, rd, err, lat, wd);
        check("lw_hi_rdata", rd, 32'h8001_BEEF);

        // stalled response with a competing request
        run_txn(1'b0, F3_W, 32'h100, 32'h0, 3, rd, err, lat, wd);
        check("stall_rdata", rd, 32'h8001_BEEF);
        check("stall_writes", wd, 0);

        // reset during a load's WAIT
        @(negedge clk);
        #1;
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h100; req_valid = 1'b1; resp_ready = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_wait_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_wait_resp_valid", {31'b0, resp_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_wait_no_resp", {31'b0, resp_valid}, 32'h0);
        end
        check("rst_wait_writes", wr_count - w0, 0);

        // reset during a store's ACCESS
        @(negedge clk);
        #1;
        req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h100; req_wdata = 32'h7777_7777;
        req_valid = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        #1 begin req_valid = 1'b0; rst = 1'b1; end
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_acc_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_acc_resp_valid", {31'b0, resp_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_acc_no_resp", {31'b0, resp_valid}, 32'h0);
        end
        check("rst_acc_writes", wr_count - w0, 0);
        check("rst_acc_mem", env_mem[15'h040], 32'h8001_BEEF);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            rst        = ($urandom_range(0, 63) == 0);
            req_valid  = $urandom_range(0, 1) == 1;
            req_we     = $urandom_range(0, 1) == 1;
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = ($urandom & 32'hFFFE_0000) | (32'h100 + 32'($urandom_range(0, 63)));
            req_wdata  = $urandom;
            resp_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous and active-high.
REQ-003 SHALL have ports: req_valid in 1 request present; req_ready out 1 unit can accept; req_we in 1 store(1)/load(0).
REQ-004 SHALL have ports: req_funct3 in 3 size code (000 B, 001 H, 010 W, 100 BU, 101 HU); req_addr in 32 byte address from ALU; req_wdata in 32 store data.
REQ-005 SHALL have ports: resp_valid out 1 response present; resp_ready in 1 consumer accepts; resp_rdata out 32 load result; resp_err out 1 access fault.
REQ-006 SHALL have ports: mem_rdaddress out 15, mem_wraddress out 15, mem_byteena out 4, mem_data out 32, mem_wren out 1, mem_q in 32; these are the word-addressed data-memory port, with mem_q registered and valid one cycle after mem_rdaddress is sampled.

Function
REQ-007 SHALL implement FSM IDLE, ACCESS, WAIT, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL, on req_valid&&req_ready (cycle T), register we/funct3/addr/wdata and enter ACCESS at T+1.
REQ-009 SHALL drive mem_rdaddress=mem_wraddress=addr[16:2] from registered address in ACCESS; addr[31:17] ignored.
REQ-010 SHALL, for a store in ACCESS, assert mem_wren for exactly one cycle with byteena B: 0001<<addr[1:0], H: 0011<<{addr[1],1'b0}, W: 1111; mem_data = {4{wdata[7:0]}} / {2{wdata[15:0]}} / wdata; then enter RESP at T+2.
REQ-011 SHALL, for a load, go ACCESS->WAIT; in WAIT, select lane from mem_q, sign-extend (B,H) or zero-extend (BU,HU), register into resp_rdata, and enter RESP at T+3.
REQ-012 SHALL hold mem_wren=0 and mem_byteena=0000 in every state except a store ACCESS.
REQ-013 SHALL assert resp_valid only in RESP; resp_rdata=0 for stores; resp_valid/resp_rdata/resp_err SHALL stay stable until resp_valid&&resp_ready, then return to IDLE next cycle.
REQ-014 SHALL treat funct3 011/110/111, and any store funct3 of 1xx, as illegal: no memory access, enter RESP at T+1 with resp_err=1, resp_rdata=0.
REQ-015 SHALL ignore req_valid in all states except IDLE; no request buffering.

Reset
REQ-016 SHALL, with rst high at a clock edge, enter IDLE and clear resp_valid, resp_rdata, resp_err, mem_wren, mem_byteena, and the request registers to 0, in any state.
REQ-017 SHALL abandon any in-flight access on reset, emit no response, and issue no write after the reset edge.

Configuration
REQ-018 SHALL use macro MISALIGN_TRAP_EN: when defined, H/HU with addr[0]=1 or W with addr[1:0]!=00 SHALL skip memory access and enter RESP at T+1 with resp_err=1, resp_rdata=0.
REQ-019 SHALL, when MISALIGN_TRAP_EN is undefined, force alignment (H uses addr[1] only, W ignores addr[1:0]), with resp_err set only by REQ-014.

Structure
REQ-020 SHALL place funct3 size constants and the FSM state enum in shared package lsu_pkg.
REQ-021 SHALL put lane selection and extension in combinational sub-module lsu_align, with inputs mem_q, addr[1:0], and funct3, and output a 32-bit result.

Verification
REQ-022 SHALL verify SW 0xDEADBEEF @0x100, then LW 0x100: wraddress=0x040, byteena=1111, one-cycle wren; LW gives resp_rdata=0xDEADBEEF at T+3.
REQ-023 SHALL verify SB 0xA5 @0x103, then LB and LBU 0x103: byteena=1000, mem_data=0xA5A5A5A5; LB gives 0xFFFFFFA5 and LBU gives 0x000000A5.
REQ-024 SHALL verify SH 0x8001 @0x102, then LH and LHU 0x102: byteena=1100; LH gives 0xFFFF8001 and LHU gives 0x00008001.
REQ-025 SHALL verify LW @0x101: with macro, resp_err=1 at T+1 and no memory access; without macro, data from word 0x040 with resp_err=0.
REQ-026 SHALL verify resp_ready held low for 3 cycles in RESP: resp_valid and resp_rdata stay stable, req_ready=0, and a concurrent req_valid is dropped.
REQ-027 SHALL verify rst asserted during a load's WAIT and during a store's ACCESS: IDLE next cycle, resp_valid=0, and no response or write follows.
